ctrl_issue_queue: RTL and testbench



---
 rtl/ctrl_pkg.sv | 22 ++
 rtl/ctrl_fifo_mem.sv | 28 ++
 rtl/ctrl_issue_queue.sv | 172 +++++++++++++++++
 tb/tb_ctrl_issue_queue.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the control-decoder issue queue: opcode, control word,
// issue FSM state and the packed FIFO entry.
package ctrl_pkg;

  localparam int CTRL_W  = 26;
  localparam int OPC_W   = 7;
  localparam int ENTRY_W = CTRL_W + OPC_W;

  typedef logic [CTRL_W-1:0] ctrl_word_t;
  typedef logic [OPC_W-1:0]  opcode_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } issue_state_e;

  typedef struct packed {
    opcode_t    opcode;
    ctrl_word_t ctrl;
  } issue_entry_t;

endpackage

// File: rtl/ctrl_fifo_mem.sv
// Storage array for the issue queue: one synchronous write port and one
// asynchronous read port so the head entry is visible without a read cycle.
module ctrl_fifo_mem
  import ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ctrl_issue_queue.sv
// Buffers decoded {opcode, control word} pairs and issues them to execute,
// holding off issue for MC_CYCLES after a multi-cycle op. Optional perf
// counters are built when CTRL_ISSUE_PERF_EN is defined.
module ctrl_issue_queue
  import ctrl_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MC_BIT    = 4,
  parameter int MC_CYCLES = 3,
  parameter int CHK_BIT   = 23,
  localparam int AW       = $clog2(DEPTH),
  localparam int CNT_W    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  opcode_t          in_opcode,
  input  ctrl_word_t       in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output opcode_t          out_opcode,
  output ctrl_word_t       out_ctrl,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             decode_err
`ifdef CTRL_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall
`endif
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [3:0]       MC_LOAD  = 4'(MC_CYCLES);

  issue_state_e     state_q, state_d;
  logic [3:0]       stall_cnt_q, stall_cnt_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q;
  logic             decode_err_q;
  logic             not_empty;
  logic             enq;
  logic             deq;
  issue_entry_t     wr_entry;
  issue_entry_t     head;

  assign not_empty = (count_q != '0);
  assign enq       = in_valid && in_ready_q && !flush;
  assign deq       = out_valid && out_ready && !flush;

  assign in_ready   = in_ready_q;
  assign out_valid  = not_empty && (state_q == RUN);
  // Head data is masked while empty so idle/reset outputs read as zero.
  assign out_opcode = not_empty ? head.opcode : '0;
  assign out_ctrl   = not_empty ? head.ctrl   : '0;
  assign count      = count_q;
  assign decode_err = decode_err_q;

  assign wr_entry.opcode = in_opcode;
  assign wr_entry.ctrl   = in_ctrl;

  ctrl_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // in_ready is registered, so a full queue refuses input for the whole
  // cycle even if the head drains on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b1;
      decode_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= (count_d != FULL_CNT);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (enq) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (enq && !in_ctrl[CHK_BIT]) begin
        decode_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      state_d     = RUN;
      stall_cnt_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (deq && out_ctrl[MC_BIT]) begin
            state_d     = STALL;
            stall_cnt_d = MC_LOAD;
          end
        end
        STALL: begin
          if (stall_cnt_q <= 4'd1) begin
            state_d     = RUN;
            stall_cnt_d = '0;
          end else begin
            stall_cnt_d = stall_cnt_q - 4'd1;
          end
        end
        default: begin
          state_d     = RUN;
          stall_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef CTRL_ISSUE_PERF_EN
  logic stall_evt;

  assign stall_evt = (state_q == STALL) || (not_empty && !out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (deq && (perf_issued != 32'hFFFF_FFFF)) begin
        perf_issued <= perf_issued + 32'd1;
      end
      if (stall_evt && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_issue_queue.sv
// Self-checking bench for ctrl_issue_queue: table-driven single issues plus
// hand-written backpressure, stall, flush, decode-check and reset sequences.
module tb_ctrl_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [25:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_opcode;
  logic [25:0] out_ctrl;
  logic        flush;
  logic [2:0]  count;
  logic        decode_err;
`ifdef CTRL_ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  ctrl_issue_queue #(
    .DEPTH     (4),
    .MC_BIT    (4),
    .MC_CYCLES (3),
    .CHK_BIT   (23)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_ctrl   (out_ctrl),
    .flush      (flush),
    .count      (count),
    .decode_err (decode_err)
`ifdef CTRL_ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_issue_cyc = 0;
  int prev_issue_cyc = 0;

  typedef struct packed {
    logic [6:0]  opc;
    logic [25:0] ctrl;
  } ent_t;

  typedef struct {
    logic [6:0]  opc;
    logic [25:0] ctrl;
    logic [2:0]  exp_cnt;
    logic        exp_vld;
    logic        exp_err;
  } vec_t;

  ent_t sb[$];
  ent_t mon_e;
  vec_t vecs[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (count != 0 && n < 20) begin
      step();
      n++;
    end
    chk(name, count, 0);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: pairs are queued on acceptance and compared on issue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("issue_unexpected", {25'd0, out_opcode}, 32'hFFFF_FFFF);
          end else begin
            mon_e = sb.pop_front();
            chk("issue_opcode", {25'd0, out_opcode}, {25'd0, mon_e.opc});
            chk("issue_ctrl", {6'd0, out_ctrl}, {6'd0, mon_e.ctrl});
          end
          prev_issue_cyc = last_issue_cyc;
          last_issue_cyc = cyc;
        end
        if (in_valid && in_ready) begin
          mon_e.opc  = in_opcode;
          mon_e.ctrl = in_ctrl;
          sb.push_back(mon_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{opc: 7'h05, ctrl: 26'h0800001, exp_cnt: 3'd1, exp_vld: 1'b1, exp_err: 1'b0};
    vecs[1] = '{opc: 7'h12, ctrl: 26'h0800102, exp_cnt: 3'd1, exp_vld: 1'b1, exp_err: 1'b0};
    vecs[2] = '{opc: 7'h3F, ctrl: 26'h0A00020, exp_cnt: 3'd1, exp_vld: 1'b1, exp_err: 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_out_opcode", out_opcode, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_decode_err", decode_err, 0);
    step();
    rst_n = 1'b1;
    step();

    // Table: single legal non-multi-cycle issues, latency one cycle.
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b1;
      in_opcode = vecs[i].opc;
      in_ctrl   = vecs[i].ctrl;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      chk("tbl_count", count, vecs[i].exp_cnt);
      chk("tbl_out_valid", out_valid, vecs[i].exp_vld);
      chk("tbl_decode_err", decode_err, vecs[i].exp_err);
      step();
      chk("tbl_count_drained", count, 0);
    end

    // Backpressure until full, then drain with a late fifth word.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_opcode = 7'h40 + 7'(i);
      in_ctrl   = 26'h0800000 | (26'(i) << 8);
      in_valid  = 1'b1;
      step();
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_count", count, 4);
    in_opcode = 7'h4F;
    in_ctrl   = 26'h0800F00;
    step();
    step();
    chk("full_hold_count", count, 4);
    chk("full_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("full_reopen_in_ready", in_ready, 1);
    chk("full_reopen_count", count, 3);
    step();
    in_valid = 1'b0;
    chk("full_fifth_count", count, 3);
    drain("full_drain");

    // Multi-cycle stall with an enqueue during the stall window.
    out_ready = 1'b1;
    in_opcode = 7'h11;
    in_ctrl   = 26'h0800010;
    in_valid  = 1'b1;
    step();
    in_opcode = 7'h22;
    in_ctrl   = 26'h0800000;
    step();
    in_opcode = 7'h33;
    in_ctrl   = 26'h0800100;
    chk("stall_vld_1", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("stall_vld_2", out_valid, 0);
    chk("stall_enq_count", count, 2);
    step();
    chk("stall_vld_3", out_valid, 0);
    step();
    chk("stall_resume_vld", out_valid, 1);
    @(negedge clk);
    #1;
    chk("stall_issue_gap", last_issue_cyc - prev_issue_cyc, 4);
    drain("stall_drain");

    // Flush with an in-flight word.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_opcode = 7'h60 + 7'(i);
      in_ctrl   = 26'h0800000 | 26'(i);
      in_valid  = 1'b1;
      step();
    end
    chk("flush_pre_count", count, 3);
    in_opcode = 7'h6D;
    in_ctrl   = 26'h0800ABC;
    flush     = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_decode_err", decode_err, 0);
    out_ready = 1'b1;
    step();
    step();
    chk("flush_no_ghost", out_valid, 0);

    // Sticky decode error survives flush, cleared by reset.
    in_opcode = 7'h2A;
    in_ctrl   = 26'h0000001;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    chk("derr_set", decode_err, 1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("derr_after_flush", decode_err, 1);
    rst_n = 1'b0;
    #1;
    chk("derr_reset", decode_err, 0);
    sb.delete();
    step();
    rst_n = 1'b1;
    step();

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b1;
    in_opcode = 7'h44;
    in_ctrl   = 26'h0800010;
    in_valid  = 1'b1;
    step();
    in_opcode = 7'h55;
    in_ctrl   = 26'h0800000;
    step();
    in_valid = 1'b0;
    chk("arst_pre_vld", out_valid, 0);
    chk("arst_pre_count", count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_ctrl", out_ctrl, 0);
    chk("arst_out_opcode", out_opcode, 0);
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("arst_empty_vld", out_valid, 0);
    chk("arst_empty_count", count, 0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
